mealy_seq_detector: RTL and testbench

MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

---
 rtl/mealy_pkg.sv | 24 ++
 rtl/seq_next_state.sv | 50 +++++
 rtl/mealy_seq_detector.sv | 78 +++++++
 tb/tb_mealy_seq_detector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_pkg.sv
// Shared defaults and helpers for the Mealy sequence detector.
// Holds the state-width function and the saturating match-counter increment.
package mealy_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

  // Width of the matched-prefix state; never narrower than one bit.
  function automatic int state_w(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational KMP-style fallback: from matched-prefix length k and the new bit,
// find the longest pattern prefix that ends the extended prefix, and flag a full match.
module seq_next_state
  import mealy_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  localparam int SW    = state_w(PAT_W)
) (
  input  logic [PAT_W-1:0] pattern,
  input  logic [SW-1:0]    k,
  input  logic             in_bit,
  output logic [SW-1:0]    next_k,
  output logic             full
);

  logic s [PAT_W];
  int   ki;
  int   best;
  int   pos;
  logic ok;

  always_comb begin
    ki     = int'(k);
    best   = 0;
    pos    = 0;
    ok     = 1'b0;
    next_k = '0;
    full   = 1'b0;
    // s = first k pattern bits followed by the incoming bit
    for (int i = 0; i < PAT_W; i++) begin
      if (i < ki)       s[i] = pattern[PAT_W-1-i];
      else if (i == ki) s[i] = in_bit;
      else              s[i] = 1'b0;
    end
    // Ascending j so the longest matching prefix wins.
    for (int j = 1; j < PAT_W; j++) begin
      ok = (j <= ki + 1);
      for (int i = 0; i < PAT_W - 1; i++) begin
        pos = ki + 1 - j + i;
        if (ok && (i < j) && (pos >= 0) && (pos < PAT_W)) begin
          if (s[pos] != pattern[PAT_W-1-i]) ok = 1'b0;
        end
      end
      if (ok) best = j;
    end
    full   = (ki == PAT_W - 1) && (in_bit == pattern[0]);
    next_k = SW'(best);
  end

endmodule

// File: rtl/mealy_seq_detector.sv
// Configurable serial pattern detector with Mealy match output and saturating counter.
// The registered matched-prefix length is exposed on current_state.
module mealy_seq_detector
  import mealy_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_load,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic                     cfg_overlap,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     out,
  output logic [CNT_W-1:0]         match_count,
  output logic [$clog2(PAT_W)-1:0] current_state
);

  localparam int SW = state_w(PAT_W);

  logic [PAT_W-1:0] pat_q;
  mode_e            mode_q;
  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    fb_k;
  logic             full;
  logic             out_c;

  seq_next_state #(.PAT_W(PAT_W)) u_next (
    .pattern (pat_q),
    .k       (state_q),
    .in_bit  (in_bit),
    .next_k  (fb_k),
    .full    (full)
  );

  // in_valid qualifies in_bit; there is no backpressure: a sample is consumed on
  // every rising edge with in_valid=1 and cfg_load=0, and cfg_load wins over a sample.
  always_comb begin
    state_d = state_q;
    out_c   = 1'b0;
    if (cfg_load) begin
      state_d = '0;
    end else if (in_valid) begin
      out_c = full;
      if (full && (mode_q == MODE_NONOVL)) state_d = '0;
      else                                 state_d = fb_k;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_c) cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      mode_q  <= MODE_OVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cfg_load) begin
        pat_q  <= cfg_pattern;
        mode_q <= mode_e'(cfg_overlap);
      end
    end
  end

  assign out           = out_c & reset_n;
  assign match_count   = cnt_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: a PAT_W=4/CNT_W=8 instance and a PAT_W=2/CNT_W=2 instance,
// driven from a vector table plus hand-written reset/config sequences.
module tb_mealy_seq_detector;

  typedef struct {
    logic       sel;
    logic       load;
    logic [3:0] pat;
    logic       ovl;
    logic       v;
    logic       b;
    logic       eout;
    logic [3:0] est;
    logic [7:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;

  logic       load_a, ovl_a, valid_a, bit_a, out_a;
  logic [3:0] pat_a;
  logic [7:0] cnt_a;
  logic [1:0] state_a;

  logic       load_b, ovl_b, valid_b, bit_b, out_b;
  logic [1:0] pat_b;
  logic [1:0] cnt_b;
  logic [0:0] state_b;

  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];
  vec_t tbl[80];
  int n_vec = 0;

  always #5 clk = ~clk;

  mealy_seq_detector #(.PAT_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .cfg_load(load_a), .cfg_pattern(pat_a),
    .cfg_overlap(ovl_a), .in_valid(valid_a), .in_bit(bit_a), .out(out_a),
    .match_count(cnt_a), .current_state(state_a)
  );

  mealy_seq_detector #(.PAT_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .cfg_load(load_b), .cfg_pattern(pat_b),
    .cfg_overlap(ovl_b), .in_valid(valid_b), .in_bit(bit_b), .out(out_b),
    .match_count(cnt_b), .current_state(state_b)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [12:0] exp;
    logic        aout;
    @(negedge clk);
    if (!t.sel) begin
      load_a = t.load; pat_a = t.pat; ovl_a = t.ovl; valid_a = t.v; bit_a = t.b;
    end else begin
      load_b = t.load; pat_b = t.pat[1:0]; ovl_b = t.ovl; valid_b = t.v; bit_b = t.b;
    end
    exp_q.push_back({t.eout, t.est, t.ecnt});
    #1;
    aout = t.sel ? out_b : out_a;
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("out", idx, 32'(aout), 32'(exp[12]));
    if (!t.sel) begin
      check("state", idx, 32'(state_a), 32'(exp[11:8]));
      check("count", idx, 32'(cnt_a), 32'(exp[7:0]));
    end else begin
      check("state_b", idx, 32'(state_b), 32'(exp[11:8]));
      check("count_b", idx, 32'(cnt_b), 32'(exp[7:0]));
    end
    load_a = 1'b0; valid_a = 1'b0; load_b = 1'b0; valid_b = 1'b0;
  endtask

  task automatic add(input logic sel, input logic load, input logic [3:0] pat,
                     input logic ovl, input logic v, input logic b,
                     input logic eout, input logic [3:0] est, input logic [7:0] ecnt);
    tbl[n_vec] = '{sel, load, pat, ovl, v, b, eout, est, ecnt};
    n_vec++;
  endtask

  task automatic step(input logic sel, input logic load, input logic [3:0] pat,
                      input logic ovl, input logic v, input logic b,
                      input logic eout, input logic [3:0] est, input logic [7:0] ecnt,
                      input int idx);
    vec_t t;
    t = '{sel, load, pat, ovl, v, b, eout, est, ecnt};
    apply(t, idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pattern 0101, overlap: matches on bits 4 and 6.
    add(0, 1, 4'b0101, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0, 2, 0);
    add(0, 0, 0, 0, 1, 0, 0, 3, 0);
    add(0, 0, 0, 0, 1, 1, 1, 2, 1);
    add(0, 0, 0, 0, 1, 0, 0, 3, 1);
    add(0, 0, 0, 0, 1, 1, 1, 2, 2);
    // Same stream, non-overlap: one match only.
    add(0, 1, 4'b0101, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 1, 0, 2, 2);
    add(0, 0, 0, 0, 1, 0, 0, 3, 2);
    add(0, 0, 0, 0, 1, 1, 1, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 1, 3);
    add(0, 0, 0, 0, 1, 1, 0, 2, 3);
    add(0, 0, 0, 0, 0, 1, 0, 2, 3);
    // Fallback walk 0,0,1,1,1 -> 1,1,2,0,0; load ignores the sample.
    add(0, 1, 4'b0101, 1, 1, 0, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 1, 3);
    add(0, 0, 0, 0, 1, 0, 0, 1, 3);
    add(0, 0, 0, 0, 1, 1, 0, 2, 3);
    add(0, 0, 0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 1, 0, 0, 3);
    // Mismatch in the last state falls back to 1; idle in state 3 holds.
    add(0, 0, 0, 0, 1, 0, 0, 1, 3);
    add(0, 0, 0, 0, 1, 1, 0, 2, 3);
    add(0, 0, 0, 0, 1, 0, 0, 3, 3);
    add(0, 0, 0, 0, 1, 0, 0, 1, 3);
    add(0, 0, 0, 0, 1, 1, 0, 2, 3);
    add(0, 0, 0, 0, 1, 0, 0, 3, 3);
    add(0, 0, 0, 0, 0, 1, 0, 3, 3);
    add(0, 0, 0, 0, 1, 1, 1, 2, 4);
    // Reload 0011 from state 2, then 0,0,1,1 matches; no border -> 0.
    add(0, 1, 4'b0011, 1, 1, 1, 0, 0, 4);
    add(0, 0, 0, 0, 1, 0, 0, 1, 4);
    add(0, 0, 0, 0, 1, 0, 0, 2, 4);
    add(0, 0, 0, 0, 1, 1, 0, 3, 4);
    add(0, 0, 0, 0, 1, 1, 1, 0, 5);
    // cfg_load masks what would be a completing bit.
    add(0, 0, 0, 0, 1, 0, 0, 1, 5);
    add(0, 0, 0, 0, 1, 0, 0, 2, 5);
    add(0, 0, 0, 0, 1, 1, 0, 3, 5);
    add(0, 1, 4'b0011, 1, 1, 1, 0, 0, 5);
    // PAT_W=2, CNT_W=2: six 1s with pattern 11 -> five matches, saturating at 3.
    add(1, 1, 4'b0011, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 1, 1, 1, 1);
    add(1, 0, 0, 0, 1, 1, 1, 1, 2);
    add(1, 0, 0, 0, 1, 1, 1, 1, 3);
    add(1, 0, 0, 0, 1, 1, 1, 1, 3);
    add(1, 0, 0, 0, 1, 1, 1, 1, 3);
    add(1, 1, 4'b0011, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 1, 1, 0, 1, 3);
    add(1, 0, 0, 0, 1, 1, 1, 0, 3);
    add(1, 0, 0, 0, 1, 1, 0, 1, 3);

    // Reset block
    reset_n = 1'b0;
    load_a = 0; pat_a = 0; ovl_a = 0; valid_a = 1; bit_a = 0;
    load_b = 0; pat_b = 0; ovl_b = 0; valid_b = 0; bit_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 0, 32'(out_a), 0);
    check("reset_state", 0, 32'(state_a), 0);
    check("reset_count", 0, 32'(cnt_a), 0);
    check("reset_state_b", 0, 32'(state_b), 0);
    check("reset_count_b", 0, 32'(cnt_b), 0);
    @(negedge clk);
    valid_a = 0;
    reset_n = 1'b1;

    for (int i = 0; i < n_vec; i++) apply(tbl[i], i);

    // Mid-stream asynchronous reset: 0011 prefix reaches state 3, then reset between edges.
    step(0, 0, 0, 0, 1, 0, 0, 1, 5, 100);
    step(0, 0, 0, 0, 1, 0, 0, 2, 5, 101);
    step(0, 0, 0, 0, 1, 1, 0, 3, 5, 102);
    @(negedge clk);
    valid_a = 1; bit_a = 1;
    #1;
    check("pre_reset_out", 103, 32'(out_a), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_state", 103, 32'(state_a), 0);
    check("async_reset_count", 103, 32'(cnt_a), 0);
    check("async_reset_out", 103, 32'(out_a), 0);
    check("async_reset_count_b", 103, 32'(cnt_b), 0);
    @(posedge clk);
    #1;
    check("held_reset_state", 104, 32'(state_a), 0);
    check("held_reset_count", 104, 32'(cnt_a), 0);
    @(negedge clk);
    valid_a = 0;
    reset_n = 1'b1;
    // Pattern resets to 0000 with overlap on: border of 0000 is 3.
    step(0, 0, 0, 0, 1, 0, 0, 1, 0, 110);
    step(0, 0, 0, 0, 1, 0, 0, 2, 0, 111);
    step(0, 0, 0, 0, 1, 0, 0, 3, 0, 112);
    step(0, 0, 0, 0, 1, 0, 1, 3, 1, 113);
    step(0, 0, 0, 0, 1, 0, 1, 3, 2, 114);
    // Reload 0101, stream 1,0,1,0,1: single match on the last bit.
    step(0, 1, 4'b0101, 1, 0, 0, 0, 0, 2, 120);
    step(0, 0, 0, 0, 1, 1, 0, 0, 2, 121);
    step(0, 0, 0, 0, 1, 0, 0, 1, 2, 122);
    step(0, 0, 0, 0, 1, 1, 0, 2, 2, 123);
    step(0, 0, 0, 0, 1, 0, 0, 3, 2, 124);
    step(0, 0, 0, 0, 1, 1, 1, 2, 3, 125);

    check("queue_drained", 200, 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
